// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register bank: pointer write, burst write, burst read, no clock stretching.
// Optional I2C_TGT_GLITCH_FILTER_EN adds a 3-sample agreement filter after each input synchronizer.
module i2c_target_regs #(
    parameter logic [6:0] TGT_ADDR = 7'h50,
    parameter int         NUM_REGS = 8,
    localparam int        IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic [8*NUM_REGS-1:0] regs_o,
    output logic                  wr_valid,
    output logic [IDX_W-1:0]      wr_idx,
    output logic [7:0]            wr_data,
    output logic                  busy
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WRITE, ST_WRITE_ACK, ST_READ, ST_RD_ACK
    } state_t;

    logic             rst_meta_r, rst_r;
    logic [1:0]       scl_sync_r, sda_sync_r;
    logic             scl_s, sda_s, scl_prev_r, sda_prev_r;
    logic             scl_rise_s, scl_fall_s, start_s, stop_s, last_bit_s;
    logic [7:0]       byte_s, rd_byte_s;
    logic [IDX_W-1:0] ptr_inc_s;
    state_t           state_r, state_nxt;
    logic [3:0]       cnt_r, cnt_nxt;
    logic [7:0]       shift_r, shift_nxt;
    logic [IDX_W-1:0] ptr_r, ptr_nxt;
    logic             rw_r, rw_nxt;
    logic             sda_oe_r, sda_oe_nxt, busy_r, busy_nxt;
    logic             wr_valid_r, wr_valid_nxt;
    logic [IDX_W-1:0] wr_idx_r, wr_idx_nxt;
    logic [7:0]       wr_data_r, wr_data_nxt;
    logic             reg_we_s;
    logic [7:0]       regs_r [NUM_REGS];

    // Reset synchronizer: asserts immediately, releases two clocks later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_meta_r <= 1'b1;
            rst_r      <= 1'b1;
        end else begin
            rst_meta_r <= 1'b0;
            rst_r      <= rst_meta_r;
        end
    end

    // Two-flop synchronizers for the asynchronous bus lines (idle bus is high)
    always_ff @(posedge clk or posedge rst_r) begin
        if (rst_r) begin
            scl_sync_r <= 2'b11;
            sda_sync_r <= 2'b11;
        end else begin
            scl_sync_r <= {scl_sync_r[0], scl_i};
            sda_sync_r <= {sda_sync_r[0], sda_i};
        end
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [1:0] scl_hist_r, sda_hist_r;
    logic       scl_filt_r, sda_filt_r;

    function automatic logic agree3(input logic s, input logic [1:0] h, input logic cur);
        if (s & h[0] & h[1]) begin
            return 1'b1;
        end else if (~(s | h[0] | h[1])) begin
            return 1'b0;
        end else begin
            return cur;
        end
    endfunction

    // Filtered line follows only three consecutive agreeing samples
    always_ff @(posedge clk or posedge rst_r) begin
        if (rst_r) begin
            scl_hist_r <= 2'b11;
            sda_hist_r <= 2'b11;
            scl_filt_r <= 1'b1;
            sda_filt_r <= 1'b1;
        end else begin
            scl_hist_r <= {scl_hist_r[0], scl_sync_r[1]};
            sda_hist_r <= {sda_hist_r[0], sda_sync_r[1]};
            scl_filt_r <= agree3(scl_sync_r[1], scl_hist_r, scl_filt_r);
            sda_filt_r <= agree3(sda_sync_r[1], sda_hist_r, sda_filt_r);
        end
    end

    assign scl_s = scl_filt_r;
    assign sda_s = sda_filt_r;
`else
    assign scl_s = scl_sync_r[1];
    assign sda_s = sda_sync_r[1];
`endif

    // Previous line values for edge and START/STOP detection
    always_ff @(posedge clk or posedge rst_r) begin
        if (rst_r) begin
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_prev_r <= scl_s;
            sda_prev_r <= sda_s;
        end
    end

    assign scl_rise_s = scl_s & ~scl_prev_r;
    assign scl_fall_s = ~scl_s & scl_prev_r;
    assign start_s    = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
    assign stop_s     = scl_s & scl_prev_r & ~sda_prev_r & sda_s;
    assign byte_s     = {shift_r[6:0], sda_s};
    assign last_bit_s = (cnt_r == 4'd7);
    assign rd_byte_s  = regs_r[ptr_r];
    assign ptr_inc_s  = ptr_r + IDX_W'(1);

    // Next-state and next-output logic; ACK states use sda_oe_r to tell first from second SCL fall
    always_comb begin
        state_nxt    = state_r;
        cnt_nxt      = cnt_r;
        shift_nxt    = shift_r;
        ptr_nxt      = ptr_r;
        rw_nxt       = rw_r;
        sda_oe_nxt   = sda_oe_r;
        busy_nxt     = busy_r;
        wr_valid_nxt = 1'b0;
        wr_idx_nxt   = wr_idx_r;
        wr_data_nxt  = wr_data_r;
        reg_we_s     = 1'b0;
        if (stop_s) begin
            state_nxt  = ST_IDLE;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
            cnt_nxt    = 4'd0;
        end else if (start_s) begin
            state_nxt  = ST_ADDR;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
            cnt_nxt    = 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sda_oe_nxt = 1'b0;
                end
                ST_ADDR, ST_PTR, ST_WRITE: begin
                    if (scl_rise_s) begin
                        shift_nxt = byte_s;
                        if (last_bit_s) begin
                            cnt_nxt = 4'd0;
                            if (state_r == ST_ADDR) begin
                                rw_nxt = byte_s[0];
                                if (byte_s[7:1] == TGT_ADDR) begin
                                    state_nxt = ST_ADDR_ACK;
                                    busy_nxt  = 1'b1;
                                end else begin
                                    state_nxt = ST_IDLE;
                                end
                            end else if (state_r == ST_PTR) begin
                                ptr_nxt   = byte_s[IDX_W-1:0];
                                state_nxt = ST_PTR_ACK;
                            end else begin
                                reg_we_s     = 1'b1;
                                wr_valid_nxt = 1'b1;
                                wr_idx_nxt   = ptr_r;
                                wr_data_nxt  = byte_s;
                                ptr_nxt      = ptr_inc_s;
                                state_nxt    = ST_WRITE_ACK;
                            end
                        end else begin
                            cnt_nxt = cnt_r + 4'd1;
                        end
                    end else begin
                        shift_nxt = shift_r;
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WRITE_ACK: begin
                    if (scl_fall_s) begin
                        if (!sda_oe_r) begin
                            sda_oe_nxt = 1'b1;
                        end else if ((state_r == ST_ADDR_ACK) && rw_r) begin
                            // End of ACK is also the start of the first read bit
                            state_nxt  = ST_READ;
                            shift_nxt  = {rd_byte_s[6:0], 1'b0};
                            sda_oe_nxt = ~rd_byte_s[7];
                            cnt_nxt    = 4'd1;
                        end else begin
                            state_nxt  = (state_r == ST_ADDR_ACK) ? ST_PTR : ST_WRITE;
                            sda_oe_nxt = 1'b0;
                            cnt_nxt    = 4'd0;
                        end
                    end else begin
                        sda_oe_nxt = sda_oe_r;
                    end
                end
                ST_READ: begin
                    if (scl_fall_s) begin
                        if (cnt_r == 4'd8) begin
                            sda_oe_nxt = 1'b0;
                            ptr_nxt    = ptr_inc_s;
                            state_nxt  = ST_RD_ACK;
                            cnt_nxt    = 4'd0;
                        end else begin
                            sda_oe_nxt = ~shift_r[7];
                            shift_nxt  = {shift_r[6:0], 1'b0};
                            cnt_nxt    = cnt_r + 4'd1;
                        end
                    end else begin
                        sda_oe_nxt = sda_oe_r;
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise_s) begin
                        if (sda_s) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt = ST_READ;
                            shift_nxt = rd_byte_s;
                            cnt_nxt   = 4'd0;
                        end
                    end else begin
                        state_nxt = ST_RD_ACK;
                    end
                end
                default: begin
                    state_nxt  = ST_IDLE;
                    sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    // Controller state and registered outputs
    always_ff @(posedge clk or posedge rst_r) begin
        if (rst_r) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            shift_r    <= 8'h00;
            ptr_r      <= '0;
            rw_r       <= 1'b0;
            sda_oe_r   <= 1'b0;
            busy_r     <= 1'b0;
            wr_valid_r <= 1'b0;
            wr_idx_r   <= '0;
            wr_data_r  <= 8'h00;
        end else begin
            state_r    <= state_nxt;
            cnt_r      <= cnt_nxt;
            shift_r    <= shift_nxt;
            ptr_r      <= ptr_nxt;
            rw_r       <= rw_nxt;
            sda_oe_r   <= sda_oe_nxt;
            busy_r     <= busy_nxt;
            wr_valid_r <= wr_valid_nxt;
            wr_idx_r   <= wr_idx_nxt;
            wr_data_r  <= wr_data_nxt;
        end
    end

    // Register bank, written only by the bus write path
    always_ff @(posedge clk or posedge rst_r) begin
        if (rst_r) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_r[k] <= 8'h00;
            end
        end else if (reg_we_s) begin
            regs_r[ptr_r] <= byte_s;
        end else begin
            regs_r[ptr_r] <= regs_r[ptr_r];
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[8*g +: 8] = regs_r[g];
    end

    assign sda_oe   = sda_oe_r;
    assign busy     = busy_r;
    assign wr_valid = wr_valid_r;
    assign wr_idx   = wr_idx_r;
    assign wr_data  = wr_data_r;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-level I2C initiator, register-bank model, scoreboard queues for writes and reads.
module tb_i2c_target_regs;

    localparam int NREG = 8;
    localparam int Q    = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 scl_m, sda_m;
    logic                 sda_line;
    logic                 sda_oe;
    logic [8*NREG-1:0]    regs_o;
    logic                 wr_valid;
    logic [2:0]           wr_idx;
    logic [7:0]           wr_data;
    logic                 busy;

    assign sda_line = sda_m & ~sda_oe;

    i2c_target_regs #(.TGT_ADDR(7'h50), .NUM_REGS(NREG)) dut (
        .clk(clk), .reset(reset), .scl_i(scl_m), .sda_i(sda_line),
        .sda_oe(sda_oe), .regs_o(regs_o), .wr_valid(wr_valid),
        .wr_idx(wr_idx), .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { int idx; logic [7:0] data; } wr_t;
    wr_t        exp_wr_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] obs_rd_q[$];
    logic [7:0] m_regs[NREG];
    int         m_ptr;
    wr_t        mon_e;
    logic [7:0] mon_b;
    logic       watch = 1'b0;
    logic       oe_seen, busy_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every wr_valid pulse must match the oldest expected write
    always @(negedge clk) begin
        if (wr_valid) begin
            if (exp_wr_q.size() == 0) begin
                check("unexpected_wr_valid", 32'(1), 32'(0));
            end else begin
                mon_e = exp_wr_q.pop_front();
                check("wr_idx", 32'(wr_idx), 32'(mon_e.idx));
                check("wr_data", 32'(wr_data), 32'(mon_e.data));
            end
        end
    end

    // Read monitor: bytes seen on the bus against model predictions
    always @(negedge clk) begin
        if (obs_rd_q.size() > 0) begin
            mon_b = obs_rd_q.pop_front();
            if (exp_rd_q.size() == 0) begin
                check("unexpected_read", 32'(1), 32'(0));
            end else begin
                check("rd_data", 32'(mon_b), 32'(exp_rd_q.pop_front()));
            end
        end
    end

    // Sticky flags for windows where the target must stay silent
    always @(negedge clk) begin
        if (!watch) begin
            oe_seen   <= 1'b0;
            busy_seen <= 1'b0;
        end else begin
            if (sda_oe) oe_seen <= 1'b1;
            if (busy)   busy_seen <= 1'b1;
        end
    end

    task automatic clkn(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        if (scl_m == 1'b0) begin
            clkn(2); sda_m = 1'b1; clkn(Q - 2); scl_m = 1'b1; clkn(Q);
        end else begin
            clkn(Q);
        end
        sda_m = 1'b0; clkn(Q); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        clkn(2); sda_m = 1'b0; clkn(Q - 2); scl_m = 1'b1; clkn(Q); sda_m = 1'b1; clkn(Q);
    endtask

    task automatic send_bit(input logic b);
        clkn(2); sda_m = b; clkn(Q - 2); scl_m = 1'b1; clkn(2 * Q); scl_m = 1'b0;
    endtask

    task automatic recv_bit(input logic drive, output logic b);
        clkn(2); sda_m = drive; clkn(Q - 2); scl_m = 1'b1; clkn(Q); b = sda_line; clkn(Q); scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic unused_b;
        for (int i = 7; i >= 0; i--) recv_bit(1'b1, b[i]);
        clkn(2); sda_m = nack; clkn(Q - 2); scl_m = 1'b1; clkn(Q);
        check("rd_ack_released", 32'(sda_oe), 32'(0));
        unused_b = sda_line;
        clkn(Q); scl_m = 1'b0;
    endtask

    task automatic addr_ptr(input logic [7:0] ptr);
        logic ack;
        i2c_start();
        write_byte(8'hA0, ack);
        check("addr_w_ack", 32'(ack), 32'(0));
        check("busy_after_addr", 32'(busy), 32'(1));
        write_byte(ptr, ack);
        check("ptr_ack", 32'(ack), 32'(0));
        m_ptr = int'(ptr) % NREG;
    endtask

    task automatic write_txn(input logic [7:0] ptr, input int n,
                             input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        logic       ack;
        logic [7:0] d;
        addr_ptr(ptr);
        for (int k = 0; k < n; k++) begin
            d = (k == 0) ? d0 : (k == 1) ? d1 : d2;
            exp_wr_q.push_back('{m_ptr, d});
            m_regs[m_ptr] = d;
            m_ptr = (m_ptr + 1) % NREG;
            write_byte(d, ack);
            check("data_ack", 32'(ack), 32'(0));
        end
        i2c_stop();
        clkn(6);
        check("busy_after_stop", 32'(busy), 32'(0));
    endtask

    task automatic read_txn(input int n, input logic with_ptr, input logic [7:0] ptr);
        logic       ack;
        logic [7:0] b;
        if (with_ptr) addr_ptr(ptr);
        i2c_start();
        write_byte(8'hA1, ack);
        check("addr_r_ack", 32'(ack), 32'(0));
        for (int k = 0; k < n; k++) begin
            exp_rd_q.push_back(m_regs[m_ptr]);
            m_ptr = (m_ptr + 1) % NREG;
            read_byte(k == n - 1, b);
            obs_rd_q.push_back(b);
        end
        i2c_stop();
        clkn(6);
    endtask

    task automatic cmp_regs(input string name);
        for (int k = 0; k < NREG; k++) check(name, 32'(regs_o[8*k +: 8]), 32'(m_regs[k]));
    endtask

    initial begin
        logic       ack, b;
        logic [7:0] rp;
        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        for (int k = 0; k < NREG; k++) m_regs[k] = 8'h00;
        m_ptr = 0;
        clkn(5);
        check("rst_sda_oe", 32'(sda_oe), 32'(0));
        check("rst_regs", 32'(regs_o), 32'(0));
        check("rst_wr_valid", 32'(wr_valid), 32'(0));
        check("rst_wr_idx", 32'(wr_idx), 32'(0));
        check("rst_wr_data", 32'(wr_data), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        reset = 1'b0;
        clkn(5);

        // Basic write, combined read, pointer persistence, wrap-around
        write_txn(8'h03, 2, 8'h5A, 8'hC3, 8'h00);
        cmp_regs("regs_after_write");
        read_txn(2, 1'b1, 8'h03);
        read_txn(1, 1'b0, 8'h00);
        write_txn(8'h07, 2, 8'h11, 8'h22, 8'h00);
        cmp_regs("regs_after_wrap");

        // Address mismatch: no ACK, no busy, no write
        watch = 1'b0; clkn(2); watch = 1'b1;
        i2c_start();
        write_byte(8'hA2, ack);
        check("mismatch_addr_nack", 32'(ack), 32'(1));
        write_byte(8'h55, ack);
        check("mismatch_data_nack", 32'(ack), 32'(1));
        i2c_stop();
        check("mismatch_no_oe", 32'(oe_seen), 32'(0));
        check("mismatch_no_busy", 32'(busy_seen), 32'(0));
        watch = 1'b0;

        // Repeated START in the middle of a write byte discards it
        addr_ptr(8'h01);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        write_txn(8'h02, 1, 8'h9C, 8'h00, 8'h00);
        cmp_regs("regs_after_abort");

        // Randomized write/read traffic, pointer byte upper bits ignored
        for (int it = 0; it < 6; it++) begin
            rp = 8'($urandom_range(0, 255));
            write_txn(rp, $urandom_range(1, 3), 8'($urandom), 8'($urandom), 8'($urandom));
            rp = 8'($urandom_range(0, 255));
            read_txn($urandom_range(1, 3), 1'b1, rp);
        end
        cmp_regs("regs_after_random");

        // One-clock SDA spike while SCL high in IDLE
        clkn(10); watch = 1'b1;
        sda_m = 1'b0; clkn(1); sda_m = 1'b1;
        clkn(40);
        check("glitch_no_busy", 32'(busy_seen), 32'(0));
        check("glitch_no_oe", 32'(oe_seen), 32'(0));
        watch = 1'b0;
        write_txn(8'h06, 1, 8'h0F, 8'h00, 8'h00);

        // Reset while the target drives a read bit
        addr_ptr(8'h06);
        i2c_start();
        write_byte(8'hA1, ack);
        check("abort_addr_ack", 32'(ack), 32'(0));
        for (int i = 0; i < 3; i++) recv_bit(1'b1, b);
        clkn(2); sda_m = 1'b1; clkn(Q - 2); scl_m = 1'b1; clkn(Q);
        check("bit4_driven", 32'(sda_oe), 32'(1));
        #2 reset = 1'b1;
        #1 check("reset_drops_oe", 32'(sda_oe), 32'(0));
        scl_m = 1'b1; sda_m = 1'b1;
        clkn(3); reset = 1'b0; clkn(5);
        for (int k = 0; k < NREG; k++) m_regs[k] = 8'h00;
        m_ptr = 0;
        cmp_regs("regs_after_reset");
        check("busy_after_reset", 32'(busy), 32'(0));
        write_txn(8'h05, 1, 8'hE7, 8'h00, 8'h00);
        read_txn(2, 1'b1, 8'h04);
        read_txn(1, 1'b0, 8'h00);
        cmp_regs("regs_final");

        clkn(20);
        check("wr_queue_drained", 32'(exp_wr_q.size()), 32'(0));
        check("rd_queue_drained", 32'(exp_rd_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
